seven_segment_demux: RTL and testbench
======================================

Name: seven_segment_demux

Overview:
- Receive-side counterpart of the four-digit seven-segment multiplexer.
- Samples a time-multiplexed 4-bit digit bus plus active-low anode selects.
- Debounces each slot, checks the digit order 1→2→3→4, and rebuilds the four digit values.
- Publishes all four digits atomically once per complete frame. Used as a display-bus monitor/loopback checker and for forwarding display contents to remote logic.

Parameters:
- STABLE_CYCLES, 2: number of consecutive identical enabled samples needed before a slot qualifies. Legal range 1..15.

Ports:
- i_CLK  input  1  system clock; all logic on rising edge.
- i_RESET  input  1  synchronous, active-high reset.
- i_SAMPLE_EN  input  1  sample strobe; bus is sampled only on edges where this is 1.
- i_DATA  input  4  multiplexed digit value.
- i_ANODES  input  4  active-low digit select; 0111=digit1, 1011=digit2, 1101=digit3, 1110=digit4.
- o_DIGIT_1..o_DIGIT_4  output  4 each  last complete-frame digit values.
- o_FRAME_DONE  output  1  one-cycle pulse when o_DIGIT_* update.
- o_LOCKED  output  1  1 while the sequence tracker is in LOCKED.
- o_ERROR  output  1  one-cycle pulse on an illegal anode pattern or an out-of-order digit.

Behaviour:
- Reset values: o_DIGIT_* = 0, o_FRAME_DONE = 0, o_LOCKED = 0, o_ERROR = 0. Internal: FSM = HUNT, staging = 0, stable count = 0, previous sample marked invalid.
- Reset mid-frame discards all staged digits and returns to HUNT. Outputs read as reset values on the edge after i_RESET is sampled high.
- Debounce, evaluated only on i_SAMPLE_EN=1 edges; disabled edges hold all state:
  - If {i_ANODES,i_DATA} equals the previous sample, the count increments, saturating at STABLE_CYCLES.
  - Otherwise the new sample is stored and the count is set to 1. The first enabled sample after reset always counts as a change.
  - A qualified event fires once, on the edge where the count first reaches STABLE_CYCLES. With STABLE_CYCLES=1, every change qualifies.
  - A held value never re-fires.
- Event classification:
  - The four legal one-cold patterns give index d = 0..3.
  - 1111 (blank) is ignored: no error, no state change.
  - Any other pattern (0000, 0011, …) produces an o_ERROR pulse and FSM → HUNT.
- FSM states: HUNT, LOCKED. Internal registers: expect[1:0] and last[1:0].
  - HUNT: d=0 stores staging[0], sets last=0, expect=1, → LOCKED. d≠0 is ignored silently.
  - LOCKED, d==expect: store staging[d], last=d, expect=d+1 (2-bit wrap).
    - When d==3, copy staging[0..2] plus the new digit to o_DIGIT_1..4, pulse o_FRAME_DONE, and set expect=0.
  - LOCKED, d==last (data changed while the same anode is held): overwrite staging[d]. No error, no advance.
  - LOCKED, any other d: pulse o_ERROR and → HUNT.
    - If that d is 0, it is simultaneously accepted as a new frame start: staging[0] stored, expect=1, remain LOCKED.
    - o_ERROR still pulses in this case.
- Latency: a qualifying sample taken at edge N drives o_FRAME_DONE, o_ERROR and the o_DIGIT_* update at edge N+1. o_LOCKED also reflects the new state at N+1.
- Staging never leaks to outputs; o_DIGIT_* change only with o_FRAME_DONE.
- o_FRAME_DONE and o_ERROR are never high in the same cycle, because a single event is classified exactly one way.

Test Plan:
- Clean frame, STABLE_CYCLES=2, i_SAMPLE_EN=1:
  - Stimulus: digits 3,A,5,F, each slot held 4 cycles, anodes 0111/1011/1101/1110.
  - Response: one o_FRAME_DONE pulse; o_DIGIT_1..4 = 3,A,5,F; o_LOCKED=1 from the cycle after the 2nd 0111 sample; o_ERROR never 1.
- Glitch rejection:
  - Stimulus: insert a single-cycle {1011, 7} inside the digit1 slot.
  - Response: no capture of 7, no error, frame still completes with the correct values.
- Out-of-order slot:
  - Stimulus: 0111 → 1101 (skips digit2).
  - Response: o_ERROR one pulse; o_LOCKED=0; o_DIGIT_* unchanged.
  - Follow-up: a subsequent full 1→4 sequence relocks and completes.
- Illegal/blank patterns:
  - Stimulus: stable 0011.
  - Response: o_ERROR pulse, HUNT.
  - Stimulus: stable 1111 between slots.
  - Response: no error, frame completes.
- Enable gating:
  - Stimulus: i_SAMPLE_EN asserted only every 4th cycle, same frame as the clean-frame case.
  - Response: identical digits; FRAME_DONE arrives one clock after the 2nd enabled 1110 sample.
- Reset mid-frame:
  - Stimulus: assert i_RESET after digits 1–2 of a frame.
  - Response: all outputs 0 the next cycle.
  - Follow-up: digits 3–4 alone produce no FRAME_DONE; the next full frame completes.

Source files
------------

// File: rtl/seven_segment_demux.sv
// Receive side of a four-digit seven-segment multiplexed bus: debounces each
// slot, tracks digit order 1..4 and publishes complete frames atomically.
module seven_segment_demux #(
    parameter int STABLE_CYCLES = 2
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic       i_SAMPLE_EN,
    input  logic [3:0] i_DATA,
    input  logic [3:0] i_ANODES,
    output logic [3:0] o_DIGIT_1,
    output logic [3:0] o_DIGIT_2,
    output logic [3:0] o_DIGIT_3,
    output logic [3:0] o_DIGIT_4,
    output logic       o_FRAME_DONE,
    output logic       o_LOCKED,
    output logic       o_ERROR
);

    localparam logic [3:0] C_STABLE = 4'(STABLE_CYCLES);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t     r_state;
    logic [1:0] r_expect;
    logic [1:0] r_last;
    logic [3:0] r_stage_0;
    logic [3:0] r_stage_1;
    logic [3:0] r_stage_2;
    logic [7:0] r_prev;
    logic       r_prev_valid;
    logic [3:0] r_count;
    logic [3:0] r_digit_1;
    logic [3:0] r_digit_2;
    logic [3:0] r_digit_3;
    logic [3:0] r_digit_4;
    logic       r_frame_done;
    logic       r_error;

    logic [7:0] w_sample;
    logic       w_same;
    logic [3:0] w_count_nx;
    logic       w_fire;

    logic       w_legal;
    logic       w_blank;
    logic [1:0] w_idx;

    state_t     w_state_nx;
    logic [1:0] w_expect_nx;
    logic [1:0] w_last_nx;
    logic [3:0] w_stage_0_nx;
    logic [3:0] w_stage_1_nx;
    logic [3:0] w_stage_2_nx;
    logic [3:0] w_digit_1_nx;
    logic [3:0] w_digit_2_nx;
    logic [3:0] w_digit_3_nx;
    logic [3:0] w_digit_4_nx;
    logic       w_done_nx;
    logic       w_err_nx;

    assign w_sample = {i_ANODES, i_DATA};
    assign w_same   = r_prev_valid && (w_sample == r_prev);

    always_comb begin
        w_count_nx = r_count;
        if (i_SAMPLE_EN) begin
            if (!w_same) begin
                w_count_nx = 4'd1;
            end else if (r_count >= C_STABLE) begin
                w_count_nx = C_STABLE;
            end else begin
                w_count_nx = r_count + 4'd1;
            end
        end
    end

    // Fire only on the edge where the count first reaches the threshold.
    assign w_fire = i_SAMPLE_EN && (w_count_nx == C_STABLE)
                  && (!w_same || (r_count != C_STABLE));

    always_comb begin
        w_legal = 1'b1;
        w_blank = 1'b0;
        w_idx   = 2'd0;
        case (i_ANODES)
            4'b0111: w_idx = 2'd0;
            4'b1011: w_idx = 2'd1;
            4'b1101: w_idx = 2'd2;
            4'b1110: w_idx = 2'd3;
            4'b1111: w_blank = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx   = r_state;
        w_expect_nx  = r_expect;
        w_last_nx    = r_last;
        w_stage_0_nx = r_stage_0;
        w_stage_1_nx = r_stage_1;
        w_stage_2_nx = r_stage_2;
        w_digit_1_nx = r_digit_1;
        w_digit_2_nx = r_digit_2;
        w_digit_3_nx = r_digit_3;
        w_digit_4_nx = r_digit_4;
        w_done_nx    = 1'b0;
        w_err_nx     = 1'b0;

        if (w_fire && !w_blank) begin
            if (!w_legal) begin
                w_err_nx   = 1'b1;
                w_state_nx = HUNT;
            end else if (r_state == HUNT) begin
                if (w_idx == 2'd0) begin
                    w_stage_0_nx = i_DATA;
                    w_last_nx    = 2'd0;
                    w_expect_nx  = 2'd1;
                    w_state_nx   = LOCKED;
                end
            end else if (w_idx == r_expect || w_idx == r_last) begin
                // In-order advance, or new data under the same anode.
                case (w_idx)
                    2'd0:    w_stage_0_nx = i_DATA;
                    2'd1:    w_stage_1_nx = i_DATA;
                    2'd2:    w_stage_2_nx = i_DATA;
                    default: w_stage_2_nx = r_stage_2;
                endcase
                if (w_idx == r_expect) begin
                    w_last_nx   = w_idx;
                    w_expect_nx = w_idx + 2'd1;
                    if (w_idx == 2'd3) begin
                        w_digit_1_nx = r_stage_0;
                        w_digit_2_nx = r_stage_1;
                        w_digit_3_nx = r_stage_2;
                        w_digit_4_nx = i_DATA;
                        w_done_nx    = 1'b1;
                    end
                end
            end else begin
                w_err_nx = 1'b1;
                if (w_idx == 2'd0) begin
                    // Out-of-order digit 1 doubles as a fresh frame start.
                    w_stage_0_nx = i_DATA;
                    w_last_nx    = 2'd0;
                    w_expect_nx  = 2'd1;
                    w_state_nx   = LOCKED;
                end else begin
                    w_state_nx = HUNT;
                end
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_state      <= HUNT;
            r_expect     <= 2'd0;
            r_last       <= 2'd0;
            r_stage_0    <= 4'd0;
            r_stage_1    <= 4'd0;
            r_stage_2    <= 4'd0;
            r_prev       <= 8'd0;
            r_prev_valid <= 1'b0;
            r_count      <= 4'd0;
            r_digit_1    <= 4'd0;
            r_digit_2    <= 4'd0;
            r_digit_3    <= 4'd0;
            r_digit_4    <= 4'd0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_expect     <= w_expect_nx;
            r_last       <= w_last_nx;
            r_stage_0    <= w_stage_0_nx;
            r_stage_1    <= w_stage_1_nx;
            r_stage_2    <= w_stage_2_nx;
            r_count      <= w_count_nx;
            r_digit_1    <= w_digit_1_nx;
            r_digit_2    <= w_digit_2_nx;
            r_digit_3    <= w_digit_3_nx;
            r_digit_4    <= w_digit_4_nx;
            r_frame_done <= w_done_nx;
            r_error      <= w_err_nx;
            if (i_SAMPLE_EN) begin
                r_prev       <= w_sample;
                r_prev_valid <= 1'b1;
            end
        end
    end

    assign o_DIGIT_1    = r_digit_1;
    assign o_DIGIT_2    = r_digit_2;
    assign o_DIGIT_3    = r_digit_3;
    assign o_DIGIT_4    = r_digit_4;
    assign o_FRAME_DONE = r_frame_done;
    assign o_LOCKED     = (r_state == LOCKED);
    assign o_ERROR      = r_error;

endmodule

// File: tb/tb_seven_segment_demux.sv
// Directed-vector bench for seven_segment_demux with STABLE_CYCLES=2.
module tb_seven_segment_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  data;
    logic [3:0]  an;
    logic [3:0]  d1, d2, d3, d4;
    logic        done, locked, err;
    logic [15:0] digs;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;

    always #5 clk = ~clk;

    seven_segment_demux #(.STABLE_CYCLES(2)) dut (
        .i_CLK(clk),
        .i_RESET(rst),
        .i_SAMPLE_EN(en),
        .i_DATA(data),
        .i_ANODES(an),
        .o_DIGIT_1(d1),
        .o_DIGIT_2(d2),
        .o_DIGIT_3(d3),
        .o_DIGIT_4(d4),
        .o_FRAME_DONE(done),
        .o_LOCKED(locked),
        .o_ERROR(err)
    );

    assign digs = {d1, d2, d3, d4};

    task automatic step(input logic [3:0] a, input logic [3:0] d,
                        input logic e);
        an = a;
        data = d;
        en = e;
        @(posedge clk);
        #1;
        n_done += int'(done);
        n_err  += int'(err);
    endtask

    task automatic hold(input logic [3:0] a, input logic [3:0] d, input int n);
        repeat (n) step(a, d, 1'b1);
    endtask

    task automatic frame(input logic [15:0] v);
        hold(4'b0111, v[15:12], 4);
        hold(4'b1011, v[11:8], 4);
        hold(4'b1101, v[7:4], 4);
        hold(4'b1110, v[3:0], 4);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(4'b1111, 4'h0, 1'b0);
        step(4'b1111, 4'h0, 1'b0);
        checks++;
        if ({digs, done, locked, err} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%b%b%b want 0000/000",
                     digs, done, locked, err);
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_frame;
        n_done = 0;
        n_err = 0;
        step(4'b0111, 4'h3, 1'b1);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL clean_lock_early: got %b want 0", locked);
        end
        step(4'b0111, 4'h3, 1'b1);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL clean_lock: got %b want 1", locked);
        end
        hold(4'b0111, 4'h3, 2);
        hold(4'b1011, 4'hA, 4);
        hold(4'b1101, 4'h5, 4);
        checks++;
        if (digs !== 16'h0000) begin
            errors++;
            $display("FAIL clean_no_leak: got %h want 0000", digs);
        end
        step(4'b1110, 4'hF, 1'b1);
        step(4'b1110, 4'hF, 1'b1);
        checks++;
        if (done !== 1'b1 || digs !== 16'h3A5F) begin
            errors++;
            $display("FAIL clean_done: got %b/%h want 1/3a5f", done, digs);
        end
        step(4'b1110, 4'hF, 1'b1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL clean_pulse: got %b want 0", done);
        end
        step(4'b1110, 4'hF, 1'b1);
        checks++;
        if (n_done !== 1 || n_err !== 0) begin
            errors++;
            $display("FAIL clean_counts: got done=%0d err=%0d want 1/0",
                     n_done, n_err);
        end
    endtask

    task automatic test_glitch;
        n_done = 0;
        n_err = 0;
        hold(4'b0111, 4'h1, 2);
        step(4'b1011, 4'h7, 1'b1);
        hold(4'b0111, 4'h1, 3);
        hold(4'b1011, 4'h2, 4);
        hold(4'b1101, 4'h3, 4);
        hold(4'b1110, 4'h4, 4);
        checks++;
        if (n_done !== 1 || n_err !== 0 || digs !== 16'h1234) begin
            errors++;
            $display("FAIL glitch: got done=%0d err=%0d %h want 1/0 1234",
                     n_done, n_err, digs);
        end
    endtask

    task automatic test_out_of_order;
        n_done = 0;
        n_err = 0;
        hold(4'b0111, 4'h8, 4);
        step(4'b1101, 4'h9, 1'b1);
        step(4'b1101, 4'h9, 1'b1);
        checks++;
        if (err !== 1'b1 || locked !== 1'b0 || digs !== 16'h1234) begin
            errors++;
            $display("FAIL ooo_error: got %b%b %h want 10 1234",
                     err, locked, digs);
        end
        hold(4'b1101, 4'h9, 2);
        checks++;
        if (n_err !== 1) begin
            errors++;
            $display("FAIL ooo_pulses: got %0d want 1", n_err);
        end
        frame(16'h8965);
        checks++;
        if (n_done !== 1 || locked !== 1'b1 || digs !== 16'h8965) begin
            errors++;
            $display("FAIL ooo_relock: got %0d %b %h want 1 1 8965",
                     n_done, locked, digs);
        end
    endtask

    task automatic test_illegal_blank;
        n_done = 0;
        n_err = 0;
        step(4'b0011, 4'h0, 1'b1);
        step(4'b0011, 4'h0, 1'b1);
        checks++;
        if (err !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL illegal: got err=%b lock=%b want 1/0", err, locked);
        end
        hold(4'b0011, 4'h0, 2);
        n_err = 0;
        hold(4'b0111, 4'hC, 4);
        hold(4'b1111, 4'h0, 3);
        hold(4'b1011, 4'hD, 4);
        hold(4'b1111, 4'h6, 3);
        hold(4'b1101, 4'hE, 4);
        hold(4'b1111, 4'h0, 3);
        hold(4'b1110, 4'hB, 4);
        checks++;
        if (n_done !== 1 || n_err !== 0 || digs !== 16'hCDEB) begin
            errors++;
            $display("FAIL blank: got done=%0d err=%0d %h want 1/0 cdeb",
                     n_done, n_err, digs);
        end
    endtask

    task automatic test_enable_gating;
        logic [3:0] an_v [4];
        logic [3:0] d_v  [4];
        an_v = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        d_v  = '{4'h3, 4'hA, 4'h5, 4'hF};
        n_done = 0;
        n_err = 0;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) begin
                step(an_v[s], d_v[s], 1'b1);
                if (s == 3 && k == 0) begin
                    checks++;
                    if (done !== 1'b0) begin
                        errors++;
                        $display("FAIL gate_early: got %b want 0", done);
                    end
                end
                if (s == 3 && k == 1) begin
                    checks++;
                    if (done !== 1'b1 || digs !== 16'h3A5F) begin
                        errors++;
                        $display("FAIL gate_done: got %b/%h want 1/3a5f",
                                 done, digs);
                    end
                end
                repeat (3) step(an_v[s], d_v[s], 1'b0);
            end
        end
        checks++;
        if (n_done !== 1 || n_err !== 0) begin
            errors++;
            $display("FAIL gate_counts: got done=%0d err=%0d want 1/0",
                     n_done, n_err);
        end
    endtask

    task automatic test_reset_mid_frame;
        hold(4'b0111, 4'h1, 4);
        hold(4'b1011, 4'h2, 4);
        rst = 1'b1;
        step(4'b1011, 4'h2, 1'b1);
        checks++;
        if ({digs, done, locked, err} !== 19'd0) begin
            errors++;
            $display("FAIL midreset: got %h/%b%b%b want 0000/000",
                     digs, done, locked, err);
        end
        rst = 1'b0;
        n_done = 0;
        n_err = 0;
        hold(4'b1101, 4'h3, 4);
        hold(4'b1110, 4'h4, 4);
        checks++;
        if (n_done !== 0 || locked !== 1'b0 || digs !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_tail: got %0d %b %h want 0 0 0000",
                     n_done, locked, digs);
        end
        frame(16'h5678);
        checks++;
        if (n_done !== 1 || n_err !== 0 || digs !== 16'h5678) begin
            errors++;
            $display("FAIL midreset_frame: got %0d %0d %h want 1 0 5678",
                     n_done, n_err, digs);
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        data = 4'h0;
        an = 4'b1111;
        test_reset;
        test_clean_frame;
        test_glitch;
        test_out_of_order;
        test_illegal_blank;
        test_enable_gating;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
